// File: rtl/out_vc_state_pkg.sv
// Shared definitions for the output-VC state tracker:
// G-state codes, G field width and default buffer depth.
package out_vc_state_pkg;

    localparam int G_W           = 3;
    localparam int OVC_BUF_DEPTH = 8;

    typedef enum logic [G_W-1:0] {
        OVC_IDLE        = 3'b000,
        OVC_ACTIVE      = 3'b001,
        OVC_WAIT_CREDIT = 3'b010,
        OVC_DRAIN       = 3'b011
    } ovc_state_e;

endpackage

// File: rtl/out_vc_slot.sv
// One downstream VC: G-state register and credit counter.
// Ports: clk/rst, decoded per-VC hit strobes, state/cnt out,
// slot_err = protocol violation seen on this VC this cycle.
module out_vc_slot
    import out_vc_state_pkg::*;
#(
    parameter int BUF_DEPTH = OVC_BUF_DEPTH,
    parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           alloc_hit,
    input  logic           send_hit,
    input  logic           send_tail,
    input  logic           credit_hit,
    output logic [G_W-1:0] state,
    output logic [CW-1:0]  cnt,
    output logic           slot_err
);

    localparam logic [CW:0] FULL = (CW + 1)'(BUF_DEPTH);

    ovc_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          send_ok;
    logic [CW:0]   sum;
    logic          over;

    always_comb begin
        // a send with no credit left is dropped, not underflowed
        send_ok = send_hit && (cnt_q != '0);
        sum     = {1'b0, cnt_q}
                - {{CW{1'b0}}, send_ok}
                + {{CW{1'b0}}, credit_hit};
        over    = sum > FULL;
        cnt_d   = over ? FULL[CW-1:0] : sum[CW-1:0];

        slot_err = over
                 || (send_hit && (cnt_q == '0))
                 || (send_hit && (state_q == OVC_IDLE ||
                                  state_q == OVC_DRAIN))
                 || (alloc_hit && (state_q != OVC_IDLE));

        state_d = state_q;
        unique case (state_q)
            OVC_IDLE: begin
                if (alloc_hit) state_d = OVC_ACTIVE;
            end
            OVC_ACTIVE: begin
                if (send_ok) begin
                    if (send_tail)
                        state_d = (cnt_d == FULL[CW-1:0])
                                ? OVC_IDLE : OVC_DRAIN;
                    else if (cnt_d == '0)
                        state_d = OVC_WAIT_CREDIT;
                end
            end
            OVC_WAIT_CREDIT: begin
                if (cnt_d != '0) state_d = OVC_ACTIVE;
            end
            OVC_DRAIN: begin
                if (cnt_d == FULL[CW-1:0]) state_d = OVC_IDLE;
            end
            default: state_d = OVC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OVC_IDLE;
            cnt_q   <= FULL[CW-1:0];
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/out_vc_state.sv
// Per-output-port downstream VC state and credit tracker.
// Ports: alloc/send/credit strobes with one-hot VC selects in;
// packed G states, packed credit counts, has_credit, sticky err out.
module out_vc_state
    import out_vc_state_pkg::*;
#(
    parameter int VC_NUM    = 4,
    parameter int BUF_DEPTH = OVC_BUF_DEPTH,
    parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  logic [VC_NUM-1:0]     alloc_vc,
    input  logic                  send_valid,
    input  logic [VC_NUM-1:0]     send_vc,
    input  logic                  send_tail,
    input  logic                  credit_valid,
    input  logic [VC_NUM-1:0]     credit_vc,
    output logic [VC_NUM*G_W-1:0] G,
    output logic [VC_NUM*CW-1:0]  credit_cnt,
    output logic [VC_NUM-1:0]     has_credit,
    output logic                  err
);

    logic [VC_NUM-1:0] alloc_hit, send_hit, credit_hit;
    logic [VC_NUM-1:0] slot_err;
    logic              proto_err;
    logic              err_q, err_d;

    // malformed selects drop the whole event
    always_comb begin
        alloc_hit  = '0;
        send_hit   = '0;
        credit_hit = '0;
        proto_err  = 1'b0;
        if (alloc_valid) begin
            if ($onehot(alloc_vc)) alloc_hit = alloc_vc;
            else                   proto_err = 1'b1;
        end
        if (send_valid) begin
            if ($onehot(send_vc)) send_hit = send_vc;
            else                  proto_err = 1'b1;
        end
        if (credit_valid) begin
            if ($onehot(credit_vc)) credit_hit = credit_vc;
            else                    proto_err  = 1'b1;
        end
        err_d = err_q | proto_err | (|slot_err);
    end

    for (genvar i = 0; i < VC_NUM; i++) begin : g_slot
        logic [CW-1:0] cnt_w;

        out_vc_slot #(
            .BUF_DEPTH (BUF_DEPTH),
            .CW        (CW)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .alloc_hit  (alloc_hit[i]),
            .send_hit   (send_hit[i]),
            .send_tail  (send_tail),
            .credit_hit (credit_hit[i]),
            .state      (G[G_W*i +: G_W]),
            .cnt        (cnt_w),
            .slot_err   (slot_err[i])
        );

        assign credit_cnt[CW*i +: CW] = cnt_w;
        assign has_credit[i]          = |cnt_w;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;

endmodule

// File: tb/tb_out_vc_state.sv
// Bench for out_vc_state: directed scenarios then random traffic,
// every cycle compared against a behavioural per-VC model.
module tb_out_vc_state;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int CW = 4;

    localparam int S_IDLE = 0;
    localparam int S_ACT  = 1;
    localparam int S_WAIT = 2;
    localparam int S_DRN  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alloc_valid = 1'b0;
    logic [N-1:0]    alloc_vc = '0;
    logic            send_valid = 1'b0;
    logic [N-1:0]    send_vc = '0;
    logic            send_tail = 1'b0;
    logic            credit_valid = 1'b0;
    logic [N-1:0]    credit_vc = '0;
    logic [N*3-1:0]  G;
    logic [N*CW-1:0] credit_cnt;
    logic [N-1:0]    has_credit;
    logic            err;

    int checks = 0;
    int errors = 0;

    int m_st  [N];
    int m_cnt [N];
    bit m_err;

    out_vc_state #(.VC_NUM(N), .BUF_DEPTH(D), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_valid  (alloc_valid),
        .alloc_vc     (alloc_vc),
        .send_valid   (send_valid),
        .send_vc      (send_vc),
        .send_tail    (send_tail),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .G            (G),
        .credit_cnt   (credit_cnt),
        .has_credit   (has_credit),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < N; v++) begin
            m_st[v]  = S_IDLE;
            m_cnt[v] = D;
        end
        m_err = 1'b0;
    endtask

    // Applies one cycle of events to the reference VC table.
    task automatic model_step(input bit av, input bit [N-1:0] avc,
                              input bit sv, input bit [N-1:0] svc,
                              input bit tl,
                              input bit cv, input bit [N-1:0] cvc);
        bit a_ok, s_ok, c_ok;
        int nst [N];
        int ncnt [N];
        a_ok = av && ($countones(avc) == 1);
        s_ok = sv && ($countones(svc) == 1);
        c_ok = cv && ($countones(cvc) == 1);
        if (av && !a_ok) m_err = 1'b1;
        if (sv && !s_ok) m_err = 1'b1;
        if (cv && !c_ok) m_err = 1'b1;
        for (int v = 0; v < N; v++) begin
            bit a, s, c;
            int n, st;
            a  = a_ok && avc[v];
            s  = s_ok && svc[v];
            c  = c_ok && cvc[v];
            st = m_st[v];
            n  = m_cnt[v];
            if (a && st != S_IDLE) m_err = 1'b1;
            if (s && (st == S_IDLE || st == S_DRN)) m_err = 1'b1;
            if (s && n == 0) m_err = 1'b1;
            if (s && n > 0) n = n - 1;
            if (c) n = n + 1;
            if (n > D) begin
                n = D;
                m_err = 1'b1;
            end
            case (st)
                S_IDLE: if (a) st = S_ACT;
                S_ACT: if (s) begin
                    if (tl) st = (n < D) ? S_DRN : S_IDLE;
                    else if (n == 0) st = S_WAIT;
                end
                S_WAIT: if (n > 0) st = S_ACT;
                default: if (n == D) st = S_IDLE;
            endcase
            nst[v]  = st;
            ncnt[v] = n;
        end
        for (int v = 0; v < N; v++) begin
            m_st[v]  = nst[v];
            m_cnt[v] = ncnt[v];
        end
    endtask

    task automatic check_all(input string tag);
        logic [N*3-1:0]  eg;
        logic [N*CW-1:0] ec;
        logic [N-1:0]    eh;
        for (int v = 0; v < N; v++) begin
            eg[3*v +: 3]   = 3'(m_st[v]);
            ec[CW*v +: CW] = CW'(m_cnt[v]);
            eh[v]          = (m_cnt[v] != 0);
        end
        chk({tag, ".G"}, 64'(G), 64'(eg));
        chk({tag, ".cnt"}, 64'(credit_cnt), 64'(ec));
        chk({tag, ".has"}, 64'(has_credit), 64'(eh));
        chk({tag, ".err"}, 64'(err), 64'(m_err));
    endtask

    task automatic cyc(input string tag,
                       input bit av, input bit [N-1:0] avc,
                       input bit sv, input bit [N-1:0] svc,
                       input bit tl,
                       input bit cv, input bit [N-1:0] cvc);
        alloc_valid  = av;
        alloc_vc     = avc;
        send_valid   = sv;
        send_vc      = svc;
        send_tail    = tl;
        credit_valid = cv;
        credit_vc    = cvc;
        model_step(av, avc, sv, svc, tl, cv, cvc);
        @(posedge clk);
        #1;
        alloc_valid  = 1'b0;
        send_valid   = 1'b0;
        credit_valid = 1'b0;
        check_all(tag);
    endtask

    // Reset with live-looking events that must be discarded.
    task automatic do_rst(input string tag);
        rst          = 1'b1;
        alloc_valid  = 1'b1;
        alloc_vc     = 4'b0001;
        send_valid   = 1'b1;
        send_vc      = 4'b0010;
        credit_valid = 1'b1;
        credit_vc    = 4'b0110;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        alloc_valid  = 1'b0;
        send_valid   = 1'b0;
        credit_valid = 1'b0;
        model_reset();
        check_all(tag);
    endtask

    function automatic bit [N-1:0] rnd_vc();
        bit [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 9) == 0) return r[N-1:0];
        return 4'b0001 << $urandom_range(0, N - 1);
    endfunction

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_rst("reset");
        chk("rst.G", 64'(G), 64'h0);
        chk("rst.cnt", 64'(credit_cnt), 64'h8888);
        chk("rst.has", 64'(has_credit), 64'hf);

        // alloc VC1 then drain its credits
        cyc("alloc1", 1, 4'b0010, 0, 0, 0, 0, 0);
        chk("alloc1.G1", 64'(G[5:3]), 64'd1);
        for (int i = 0; i < D; i++)
            cyc("send1", 0, 0, 1, 4'b0010, 0, 0, 0);
        chk("wait1.G1", 64'(G[5:3]), 64'd2);
        chk("wait1.cnt", 64'(credit_cnt[7:4]), 64'd0);
        chk("wait1.has", 64'(has_credit[1]), 64'd0);
        chk("wait1.err", 64'(err), 64'd0);

        cyc("cred1", 0, 0, 0, 0, 0, 1, 4'b0010);
        chk("cred1.G1", 64'(G[5:3]), 64'd1);
        cyc("tail1", 0, 0, 1, 4'b0010, 1, 0, 0);
        chk("tail1.G1", 64'(G[5:3]), 64'd3);
        for (int i = 0; i < D; i++) begin
            chk("drain1.G1", 64'(G[5:3]), 64'd3);
            cyc("ret1", 0, 0, 0, 0, 0, 1, 4'b0010);
        end
        chk("idle1.G1", 64'(G[5:3]), 64'd0);

        // concurrent independent events
        cyc("alloc2", 1, 4'b0100, 0, 0, 0, 0, 0);
        cyc("alloc3", 1, 4'b1000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("send2", 0, 0, 1, 4'b0100, 0, 0, 0);
        cyc("send3", 0, 0, 1, 4'b1000, 0, 0, 0);
        cyc("sc2", 0, 0, 1, 4'b0100, 0, 1, 4'b0100);
        chk("sc2.cnt", 64'(credit_cnt[11:8]), 64'd5);
        cyc("mix", 1, 4'b0001, 1, 4'b0100, 0, 1, 4'b1000);
        chk("mix.cnt", 64'(credit_cnt), 64'h8488);

        // single-flit packet on VC0
        cyc("sf0", 0, 0, 1, 4'b0001, 1, 0, 0);
        chk("sf0.G0", 64'(G[2:0]), 64'd3);
        chk("sf0.cnt", 64'(credit_cnt[3:0]), 64'd7);
        cyc("sf0c", 0, 0, 0, 0, 0, 1, 4'b0001);
        chk("sf0c.G0", 64'(G[2:0]), 64'd0);
        chk("pre_viol.err", 64'(err), 64'd0);

        // violations
        cyc("v_alloc", 1, 4'b0100, 0, 0, 0, 0, 0);
        chk("v_alloc.err", 64'(err), 64'd1);
        do_rst("rst_a");
        cyc("v_send", 0, 0, 1, 4'b0010, 0, 0, 0);
        chk("v_send.err", 64'(err), 64'd1);
        do_rst("rst_b");
        cyc("v_cred", 0, 0, 0, 0, 0, 1, 4'b0001);
        chk("v_cred.cnt", 64'(credit_cnt[3:0]), 64'd8);
        do_rst("rst_c");
        cyc("v_hot", 1, 4'b0110, 0, 0, 0, 0, 0);
        chk("v_hot.G", 64'(G), 64'h0);
        chk("v_hot.err", 64'(err), 64'd1);

        // reset mid-packet
        do_rst("rst_d");
        cyc("alloc3b", 1, 4'b1000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc("send3b", 0, 0, 1, 4'b1000, 0, 0, 0);
        chk("pre_rst.cnt", 64'(credit_cnt[15:12]), 64'd3);
        do_rst("rst_mid");
        chk("rst_mid.G", 64'(G), 64'h0);
        chk("rst_mid.cnt", 64'(credit_cnt), 64'h8888);
        chk("rst_mid.err", 64'(err), 64'd0);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_rst("rnd_rst");
            end else begin
                cyc("rnd",
                    ($urandom_range(0, 3) == 0), rnd_vc(),
                    ($urandom_range(0, 1) == 0), rnd_vc(),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 1) == 0), rnd_vc());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
